// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : img_pkg
//  Description : Shared types and default widths for the image memory path.
//  Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

    localparam int D_WIDTH = 8;
    localparam int A_WIDTH = 16;

    typedef enum logic [0:0] {
        S_NORMAL = 1'b0,
        S_FORCE  = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        ID_DISP = 1'b0,
        ID_FILT = 1'b1
    } req_id_t;

endpackage : img_pkg
`default_nettype wire

// File: rtl/img_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : img_mem_arbiter
//  Description : Shares one single-port image RAM between the display reader
//                (port 0, fixed priority) and the median-filter engine
//                (port 1, read/write). A starvation counter forces a port-1
//                grant after STARVE_MAX consecutive denials. Read data is
//                returned one cycle after the grant to the issuing port.
//  Revision    : 1.0 - initial release
// ============================================================================
module img_mem_arbiter #(
    parameter int D_WIDTH    = img_pkg::D_WIDTH,
    parameter int A_WIDTH    = img_pkg::A_WIDTH,
    parameter int STARVE_MAX = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               R0_REQ,
    input  logic [A_WIDTH-1:0] R0_ADDR,
    output logic               R0_GNT,
    output logic               R0_RVALID,
    output logic [D_WIDTH-1:0] R0_RDATA,
    input  logic               R1_REQ,
    input  logic               R1_WE,
    input  logic [A_WIDTH-1:0] R1_ADDR,
    input  logic [D_WIDTH-1:0] R1_WDATA,
    output logic               R1_GNT,
    output logic               R1_RVALID,
    output logic [D_WIDTH-1:0] R1_RDATA,
    output logic [A_WIDTH-1:0] MEM_ADDR,
    output logic [D_WIDTH-1:0] MEM_DATA,
    output logic               MEM_WREN,
    input  logic [D_WIDTH-1:0] MEM_Q
);
    import img_pkg::*;

    // Counter value at which one more denial triggers the forced slot
    localparam logic [3:0] c_STARVE_LAST = 4'(STARVE_MAX - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [3:0]         r_starve;
    logic [3:0]         w_starve_nxt;
    logic               w_gnt0;
    logic               w_gnt1;
    logic [A_WIDTH-1:0] r_addr_hold;
    logic [D_WIDTH-1:0] r_data_hold;
    logic               r_rd_pending;
    req_id_t            r_rd_id;

    // Grant decision: port 0 wins in S_NORMAL, port 1 owns the S_FORCE slot
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!RST) begin
            case (r_state)
                S_FORCE: begin
                    w_gnt1 = R1_REQ;
                end
                default: begin
                    if (R0_REQ) begin
                        w_gnt0 = 1'b1;
                    end else begin
                        w_gnt1 = R1_REQ;
                    end
                end
            endcase
        end
    end

    // Starvation counter and next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        if (!R1_REQ || w_gnt1) begin
            w_starve_nxt = 4'd0;
        end else if (r_starve != 4'hF) begin
            w_starve_nxt = r_starve + 4'd1;
        end
        case (r_state)
            S_FORCE: begin
                // Leaves after the forced grant, or at once if port 1 went away
                w_state_nxt = S_NORMAL;
            end
            default: begin
                if (R1_REQ && !w_gnt1 && (r_starve == c_STARVE_LAST)) begin
                    w_state_nxt = S_FORCE;
                end
            end
        endcase
    end

    // State and starvation counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_NORMAL;
            r_starve <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Memory steering; idle cycles replay the last driven address/data
    always_comb begin
        MEM_ADDR = r_addr_hold;
        MEM_DATA = r_data_hold;
        MEM_WREN = 1'b0;
        if (RST) begin
            MEM_ADDR = '0;
            MEM_DATA = '0;
        end else if (w_gnt0) begin
            MEM_ADDR = R0_ADDR;
        end else if (w_gnt1) begin
            MEM_ADDR = R1_ADDR;
            if (R1_WE) begin
                MEM_DATA = R1_WDATA;
                MEM_WREN = 1'b1;
            end
        end
    end

    // Holding registers for the memory address and write data
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr_hold <= '0;
            r_data_hold <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_addr_hold <= MEM_ADDR;
            end
            if (w_gnt1 && R1_WE) begin
                r_data_hold <= R1_WDATA;
            end
        end
    end

    // Return tag: remembers who issued the read granted this cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_pending <= 1'b0;
            r_rd_id      <= ID_DISP;
        end else begin
            r_rd_pending <= w_gnt0 || (w_gnt1 && !R1_WE);
            r_rd_id      <= w_gnt1 ? ID_FILT : ID_DISP;
        end
    end

    assign R0_GNT    = w_gnt0;
    assign R1_GNT    = w_gnt1;
    assign R0_RVALID = r_rd_pending && (r_rd_id == ID_DISP) && !RST;
    assign R1_RVALID = r_rd_pending && (r_rd_id == ID_FILT) && !RST;
    assign R0_RDATA  = MEM_Q;
    assign R1_RDATA  = MEM_Q;

endmodule : img_mem_arbiter
`default_nettype wire

// File: doc/img_mem_arbiter.md
# img_mem_arbiter

Single-port image memory arbiter that shares one `RAM_IMAGE`-style instance between two requesters: the display scan-out reader (port 0, high priority) and the median-filter window engine (port 1, read/write). Port 0 has fixed priority. A starvation counter forces a port-1 grant after `STARVE_MAX` consecutive denials, so the filter keeps making progress during continuous scan-out. The block sits between the frame controller and the memory macro. It steers address, write data and write enable, and routes the 1-cycle-latency read data back to the requester that issued the read.

## Interface
- `D_WIDTH`, 8, pixel data width
- `A_WIDTH`, 16, memory address width
- `STARVE_MAX`, 4, consecutive port-1 denials before a forced grant (legal range 1..15)

Ports:
- `CLK`  in  1  single clock
- `RST`  in  1  reset, synchronous, active-high
- `R0_REQ`  in  1  display read request
- `R0_ADDR`  in  A_WIDTH  display read address
- `R0_GNT`  out  1  display request accepted this cycle
- `R0_RVALID`  out  1  `R0_RDATA` valid
- `R0_RDATA`  out  D_WIDTH  display read data
- `R1_REQ`  in  1  filter request
- `R1_WE`  in  1  1 = write, 0 = read
- `R1_ADDR`  in  A_WIDTH  filter address
- `R1_WDATA`  in  D_WIDTH  filter write data
- `R1_GNT`  out  1  filter request accepted this cycle
- `R1_RVALID`  out  1  `R1_RDATA` valid
- `R1_RDATA`  out  D_WIDTH  filter read data
- `MEM_ADDR`  out  A_WIDTH  memory address
- `MEM_DATA`  out  D_WIDTH  memory write data
- `MEM_WREN`  out  1  memory write enable
- `MEM_Q`  in  D_WIDTH  memory read data, valid 1 cycle after the address edge

## Operation
- **FSM states**
  - `S_NORMAL` (reset state): grant port 0 if `R0_REQ`, otherwise grant port 1 if `R1_REQ`.
  - `S_FORCE`: grant port 1 if `R1_REQ`, regardless of `R0_REQ`.
- **Starve counter** (4 bits, reset 0)
  - Increments in each cycle where `R1_REQ` = 1 and `R1_GNT` = 0.
  - Clears on any port-1 grant, and in any cycle where `R1_REQ` = 0.
- **Transitions**
  - `S_NORMAL` -> `S_FORCE` when a denial occurs with counter = `STARVE_MAX`-1. The counter then reaches `STARVE_MAX`.
  - `S_FORCE` -> `S_NORMAL` after the forced grant, or immediately if `R1_REQ` = 0 in `S_FORCE` (no grant issued).
- **Grants**
  - Grants are combinational from the requests and the state, and are one-hot or zero.
  - A requester holds `REQ`/`ADDR`/`WE`/`WDATA` stable until it sees `GNT`.
- **Memory steering**
  - With a grant: `MEM_ADDR` = the granted address; `MEM_WREN` = `R1_GNT & R1_WE`; `MEM_DATA` = `R1_WDATA` on a port-1 write.
  - With no grant: `MEM_WREN` = 0, and `MEM_ADDR`/`MEM_DATA` hold their last driven values from holding registers.
- **Read return**
  - A 1-deep tag register records the requester of each granted read (`rd_pending`, `rd_id`).
  - The next cycle raises that port's `RVALID` for exactly one cycle.
  - `RDATA` = `MEM_Q` on both ports; only the tagged port's `RVALID` is high.
  - Writes produce no `RVALID`.
- **Write/read ordering:** a port-1 write followed by a read of the same address in the next granted cycle returns the new data. The macro is write-first; the arbiter adds no forwarding.

## Timing
- Reset values: `R0_GNT` = `R1_GNT` = 0 while `RST` = 1; `R0_RVALID` = `R1_RVALID` = 0; `MEM_WREN` = 0; `MEM_ADDR` = 0; `MEM_DATA` = 0; state `S_NORMAL`; counter 0.
- Grant latency is 0 cycles. Read data latency is 1 cycle: grant on cycle N, `RVALID` on cycle N+1.
- Throughput is one access per cycle; back-to-back grants to either port are allowed.
- Worst-case port-1 wait under continuous `R0_REQ` is `STARVE_MAX` cycles. Worst-case port-0 wait is 1 cycle per `STARVE_MAX`+1.
- When `STARVE_MAX` = 1, port 1 gets every second slot under contention.
- If `RST` is asserted with a read in flight, the read is discarded and no `RVALID` is raised on the following cycle.
- If both ports request in `S_FORCE`, port 1 is granted and `R0_GNT` = 0.

## Structure
- Shared package `img_pkg`: `arb_state_t` enum (`S_NORMAL`, `S_FORCE`), `req_id_t` (1 bit: `ID_DISP`, `ID_FILT`), and default width constants `D_WIDTH`/`A_WIDTH`.
- Single module with no sub-modules. The grant logic, counter, FSM and return-tag register are all small.

## Test plan
- **Port 0 only:** `R0_REQ`=1 with `R0_ADDR`=0x0102 for 3 cycles -> `R0_GNT`=1 each cycle; `R0_RVALID`=1 on cycles 2-4 carrying `MEM_Q` of each address; `R1_RVALID` stays 0.
- **Starvation (`STARVE_MAX`=4):** `R0_REQ` and `R1_REQ` both held high, `R1_WE`=0 -> `R0_GNT` for 4 cycles, then `R1_GNT` on cycle 5; the pattern repeats every 5 cycles.
- **Filter write then read:** `R1_WE`=1 with `R1_ADDR`=0x00FF and `R1_WDATA`=0xA5 -> `MEM_WREN`=1 for one cycle and no `RVALID`. Next, a read of 0x00FF -> `R1_RVALID`=1 with `R1_RDATA`=0xA5.
- **Requester drop in `S_FORCE`:** enter `S_FORCE`, then drop `R1_REQ` -> no grant, state returns to `S_NORMAL`, counter = 0, and `R0` is granted the next cycle.
- **Reset mid-read:** port-0 read granted on cycle N, `RST`=1 on cycle N+1 -> `R0_RVALID`=0, `MEM_ADDR`=0, `MEM_WREN`=0, and both grants = 0 while `RST` is held.
- **Idle hold:** after a granted write to 0x1234 with 0x3C, no requests -> `MEM_ADDR` stays 0x1234, `MEM_DATA` stays 0x3C, `MEM_WREN`=0.
